// File: rtl/lcd_arbiter.sv
// lcd_arbiter: shares one lcd_controller between three clients with round-robin choice and locked multi-write sequences.
// Latency: lcd_start rises 1 cycle after a request is sampled; req_ack pulses DELAY_CYCLES+1 cycles after lcd_done is taken.
// Backpressure: clients hold req_valid until req_ack, lcd_start holds until lcd_done, and an owner may stall HOLD indefinitely.
module lcd_arbiter #(
  parameter int               CNT_W        = 18,
  parameter logic [CNT_W-1:0] DELAY_CYCLES = 18'h3FFFE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_rs,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ack,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_start,
  input  logic        lcd_done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_DONE = 3'd1;
  localparam logic [2:0] DELAY     = 3'd2;
  localparam logic [2:0] ACK       = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;

  logic [2:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic             last_q;

  // Round-robin candidate order derived from the priority pointer.
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] ptr_next;

  // Pick the first requesting client starting at ptr; a lone requester always wins.
  always_comb begin
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (ptr)
      2'd1: begin
        cand0 = 2'd1;
        cand1 = 2'd2;
        cand2 = 2'd0;
      end
      2'd2: begin
        cand0 = 2'd2;
        cand1 = 2'd0;
        cand2 = 2'd1;
      end
      default: begin
        cand0 = 2'd0;
        cand1 = 2'd1;
        cand2 = 2'd2;
      end
    endcase
    pick_vld = |req_valid;
    if (req_valid[cand0]) begin
      pick = cand0;
    end else if (req_valid[cand1]) begin
      pick = cand1;
    end else begin
      pick = cand2;
    end
    ptr_next = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
  end

  // Arbitration state machine; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      cnt       <= '0;
      last_q    <= 1'b0;
      req_ack   <= 3'b000;
      grant     <= 3'b000;
      busy      <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_start <= 1'b0;
    end else begin
      req_ack <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            grant     <= 3'b001 << pick;
            lcd_data  <= req_data[{pick, 3'b000} +: 8];
            lcd_rs    <= req_rs[pick];
            last_q    <= req_last[pick];
            lcd_start <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (lcd_done) begin
            lcd_start <= 1'b0;
            cnt       <= '0;
            state     <= DELAY;
          end
        end
        DELAY: begin
          // Settle time is DELAY_CYCLES+1 cycles; the compare stops cnt before it can wrap.
          if (cnt == DELAY_CYCLES) begin
            cnt     <= '0;
            req_ack <= grant;
            state   <= ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACK: begin
          if (last_q) begin
            grant <= 3'b000;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // Only the lock owner is serviced; everyone else waits for the release.
          if (req_valid[owner]) begin
            lcd_data  <= req_data[{owner, 3'b000} +: 8];
            lcd_rs    <= req_rs[owner];
            last_q    <= req_last[owner];
            lcd_start <= 1'b1;
            state     <= WAIT_DONE;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= 3'b000;
          busy      <= 1'b0;
          lcd_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 18'h3FFFE, post-write settle count; the settle phase lasts DELAY_CYCLES+1 cycles.
REQ-002 SHALL have parameter CNT_W, default 18, width of the settle counter.
REQ-003 clock  input  1  single rising-edge clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  3  per-client write request; client i is on bit i.
REQ-006 req_data  input  24  per-client byte; client i is on [8i+7:8i].
REQ-007 req_rs  input  3  per-client register select (0 = command, 1 = character).
REQ-008 req_last  input  3  per-client flag marking the final write of a locked sequence.
REQ-009 req_ack  output  3  one-cycle completion pulse to the owning client.
REQ-010 grant  output  3  one-hot current owner; all zeros when unowned.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 lcd_data  output  8  byte to lcd_controller data.
REQ-013 lcd_rs  output  1  to lcd_controller rs.
REQ-014 lcd_start  output  1  to lcd_controller start.
REQ-015 lcd_done  input  1  from lcd_controller done.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The state machine SHALL have states IDLE, WAIT_DONE, DELAY, ACK and HOLD.
REQ-018 In IDLE with any req_valid high, the arbiter SHALL select round-robin starting at pointer ptr (0..2, wrapping 2->0).
REQ-019 On that same IDLE edge it SHALL latch the winner's data, rs and last, set grant to the winner, set lcd_start to 1 and go to WAIT_DONE, so lcd_start rises 1 cycle after req_valid is sampled.
REQ-020 In WAIT_DONE, lcd_start SHALL stay 1 until lcd_done is sampled high; on that edge lcd_start goes to 0, the counter is cleared and the state goes to DELAY.
REQ-021 lcd_done SHALL be ignored in every state other than WAIT_DONE.
REQ-022 In DELAY, the counter SHALL increment each cycle; on the cycle where counter == DELAY_CYCLES it clears and the state goes to ACK.
REQ-023 In ACK, req_ack[owner] SHALL be 1 for exactly one cycle.
REQ-024 From ACK with the latched last = 1: grant clears, ptr becomes (owner+1) mod 3, and the state goes to IDLE.
REQ-025 From ACK with the latched last = 0: the state goes to HOLD and grant is kept.
REQ-026 In HOLD, when req_valid[owner] is high, the arbiter SHALL latch data, rs and last, set lcd_start to 1 and go to WAIT_DONE.
REQ-027 In HOLD, other clients SHALL be ignored regardless of their req_valid.
REQ-028 lcd_data and lcd_rs SHALL hold the latched values from the latch edge until the next latch; clients may change req_data after that edge.
REQ-029 A client SHALL keep req_valid high until it samples req_ack, and SHALL drop it on that edge unless it has a further write; the arbiter relies on this rule.
REQ-030 When a client other than ptr requests alone, it SHALL win immediately; ptr only defines priority order.
REQ-031 With DELAY_CYCLES = 0, DELAY SHALL last exactly 1 cycle.
REQ-032 The counter SHALL be CNT_W bits wide and SHALL never wrap within DELAY.

Reset
REQ-033 reset SHALL be sampled on the rising edge of clock only.
REQ-034 While reset is high, the state SHALL be IDLE, ptr = 0, counter = 0, and the latched last = 0.
REQ-035 While reset is high, the outputs SHALL be: lcd_start = 0, lcd_data = 8'h00, lcd_rs = 0, req_ack = 3'b000, grant = 3'b000, busy = 0.
REQ-036 Reset asserted in any state, including WAIT_DONE with lcd_start high or HOLD, SHALL abort the transfer with no req_ack pulse and release the lock.

Verification (DELAY_CYCLES = 3)
REQ-037 Single write: client 1 with data 8'h41, rs = 1, last = 1 -> lcd_start rises 1 cycle later with lcd_data = 8'h41 and lcd_rs = 1; with lcd_done returned 2 cycles after start, req_ack[1] pulses 4 cycles after the done edge, then grant = 0 and busy = 0.
REQ-038 Round-robin: all three clients request with last = 1 continuously from reset -> grant order is 0, 1, 2, 0; each receives one req_ack per write.
REQ-039 Lock: client 2 sends 3 bytes 8'h80, 8'h57, 8'h65 (last on the third) while client 0 requests throughout -> all three bytes reach lcd_data before any grant to client 0, and grant[2] stays 1 through HOLD.
REQ-040 Spurious done: lcd_done pulsed in IDLE and in DELAY -> no state change, and the DELAY length stays 4 cycles.
REQ-041 Reset mid-operation: reset asserted during WAIT_DONE -> next cycle lcd_start = 0, grant = 0, no req_ack; a following request from client 0 is granted first (ptr = 0).
REQ-042 HOLD stall: the owner drops req_valid for 10 cycles in HOLD -> the state stays HOLD with lcd_start = 0 and no other grant; the owner's reassertion resumes the transfer 1 cycle later.
